ddram_arb: RTL

- Two-requester arbiter and sequencer for the MiSTer DDR3 port (DDRAM_* Avalon-style interface), clocked in the clk_114 domain.
- Port A serves CPU fast-RAM/cache fills; port B serves RTG/video framebuffer burst reads.
- Grants one requester at a time, holds commands while DDR is busy, counts read beats and steers returned data to the owning port.

---
 rtl/ddram_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ddram_arb.sv
// rtl/ddram_arb.sv - two-port arbiter/sequencer for the DDRAM Avalon-style port
// One command outstanding at a time; read beats are counted and steered to the granted port.
module ddram_arb #(
  parameter bit RR_EN     = 1'b1,
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [28:0] a_addr,
  input  logic [7:0]  a_burst,
  input  logic [63:0] a_wdata,
  input  logic [7:0]  a_be,
  output logic        a_ack,
  output logic [63:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [28:0] b_addr,
  input  logic [7:0]  b_burst,
  input  logic [63:0] b_wdata,
  input  logic [7:0]  b_be,
  output logic        b_ack,
  output logic [63:0] b_rdata,
  output logic        b_rvalid,
  input  logic        ddr_busy,
  output logic        ddr_rd,
  output logic        ddr_we,
  output logic [28:0] ddr_addr,
  output logic [7:0]  ddr_burstcnt,
  output logic [63:0] ddr_din,
  output logic [7:0]  ddr_be,
  input  logic [63:0] ddr_dout,
  input  logic        ddr_dout_ready,
  output logic        owner
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t      state, state_nx;
  logic        rr_ptr;
  logic [7:0]  beat_cnt;
  logic        win_b, win_we, grant, accept, beat;
  logic [28:0] win_addr;
  logic [7:0]  win_burst, eff_burst, win_be;
  logic [63:0] win_wdata;

  always_comb begin
    win_b = 1'b0;
    if (a_req && b_req) win_b = RR_EN ? rr_ptr : 1'b0;
    else                win_b = b_req;
    win_we    = win_b ? b_we    : a_we;
    win_addr  = win_b ? b_addr  : a_addr;
    win_burst = win_b ? b_burst : a_burst;
    win_wdata = win_b ? b_wdata : a_wdata;
    win_be    = win_b ? b_be    : a_be;
    eff_burst = win_burst;
    if (win_burst == 8'd0)      eff_burst = 8'd1;
    else if (win_burst > MAX_B) eff_burst = MAX_B;
  end

  // The cycle carrying an ack is never a grant cycle: the acked requester
  // still shows req high then, and the other port waits one evaluation.
  assign grant  = (state == IDLE) && (a_req || b_req) && !a_ack && !b_ack;
  assign accept = (state == ISSUE) && (ddr_rd || ddr_we) && !ddr_busy;
  assign beat   = ddr_dout_ready && ((accept && ddr_rd) || (state == RDWAIT));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE: begin
        if (accept) begin
          if (ddr_we)                                state_nx = IDLE;
          else if (beat && ddr_burstcnt == 8'd1)     state_nx = IDLE;
          else                                       state_nx = RDWAIT;
        end
      end
      RDWAIT:  if (beat && beat_cnt == 8'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      beat_cnt     <= 8'd0;
      ddr_rd       <= 1'b0;
      ddr_we       <= 1'b0;
      ddr_addr     <= 29'd0;
      ddr_burstcnt <= 8'd0;
      ddr_din      <= 64'd0;
      ddr_be       <= 8'd0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= 64'd0;
      b_rdata      <= 64'd0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
    end else begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (grant) begin
        owner        <= win_b;
        ddr_rd       <= !win_we;
        ddr_we       <= win_we;
        ddr_addr     <= win_addr;
        ddr_burstcnt <= win_we ? 8'd1 : eff_burst;
        ddr_din      <= win_wdata;
        ddr_be       <= win_be;
        if (RR_EN && a_req && b_req) rr_ptr <= !win_b;
      end
      if (accept) begin
        ddr_rd <= 1'b0;
        ddr_we <= 1'b0;
        a_ack  <= !owner;
        b_ack  <= owner;
        if (ddr_rd) beat_cnt <= ddr_burstcnt - 8'(beat);
      end else if (state == RDWAIT && beat) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
      if (beat) begin
        if (owner) begin
          b_rdata  <= ddr_dout;
          b_rvalid <= 1'b1;
        end else begin
          a_rdata  <= ddr_dout;
          a_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
